refresh_row_sequencer: RTL and testbench
========================================

Name: refresh_row_sequencer

Overview:
- Initiator side of the per-row refresh-tracking interface.
- Paces refresh at a fixed interval and walks the row address space in order.
- For each row, queries the write-tracking block (drives to_refresh/Ra, samples dref).
- Requests a real REF command from the command arbiter only when dref says the row needs it; otherwise it skips the row and counts the skip.

Parameters:
- ROW_WIDTH, 16, row address width; must match the tracker's ROW_WIDTH.
- TREFI, 7800, clock cycles between refresh ticks; must be at least 2.
- MAX_DEBT, 8, maximum outstanding (postponed) ticks; must be at least 2.
- DREF_LAT, 1, cycles from the to_refresh pulse to a valid dref; legal values 0 or 1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, interval counting allowed.
- to_refresh, out, 1, one-cycle query strobe to the tracker.
- Ra, out, ROW_WIDTH, row being queried; valid while to_refresh=1.
- dref, in, 1, tracker verdict: 1 = row needs refresh.
- ref_req, out, 1, REF request to the arbiter; held until ack.
- ref_row, out, ROW_WIDTH, row for the REF; stable while ref_req=1.
- ref_ack, in, 1, arbiter accepts the REF.
- urgent, out, 1, debt == MAX_DEBT.
- round_done, out, 1, one-cycle pulse when the row pointer wraps to 0.
- skip_cnt, out, 16, saturating count of skipped rows.
- debt_ovf, out, 1, sticky: a tick was lost at MAX_DEBT.

Behaviour:
- Reset (async, rst=1):
  - Interval counter, row pointer, debt, skip_cnt = 0.
  - FSM = IDLE.
  - All outputs 0, Ra = 0, ref_row = 0.
- Interval counter:
  - While enable=1, counts 0..TREFI-1.
  - tick = (count == TREFI-1) && enable; the counter then wraps to 0.
  - enable=0 freezes the count; it does not clear it.
- Debt counter, 0..MAX_DEBT, updated each cycle:
  - Increments on tick.
  - Decrements on row completion (skip decision, or ref_req && ref_ack).
  - Tick and completion in the same cycle: unchanged.
  - Tick while debt == MAX_DEBT with no completion that cycle: debt stays MAX_DEBT and debt_ovf sets. debt_ovf clears only on reset.
- FSM states:
  - IDLE: if debt > 0, go to QUERY. Tick and debt in the same cycle do not bypass the registered debt.
  - QUERY: to_refresh=1 and Ra=row pointer for exactly one cycle.
    - DREF_LAT=0: dref is sampled in this cycle; go to DECIDE with the value registered.
    - DREF_LAT=1: go to WAIT.
  - WAIT: sample dref this cycle, go to DECIDE.
  - DECIDE:
    - dref=1: load ref_row = row pointer, go to ISSUE.
    - dref=0: this is the skip completion. skip_cnt += 1 (saturating at 0xFFFF), advance the pointer, go to IDLE.
  - ISSUE: ref_req=1 with ref_row held.
    - On ref_ack: completion, ref_req drops the next cycle, advance the pointer, go to IDLE.
    - ref_ack while ref_req=0 is ignored.
- Pointer advance:
  - row pointer + 1 modulo 2^ROW_WIDTH.
  - On the wrap from all-ones to 0, round_done pulses in the advancing cycle.
- Throughput: skipped rows take 3 cycles (QUERY/WAIT/DECIDE, DREF_LAT=1) plus 1 IDLE cycle.
- urgent is combinational from registered debt.
- enable=0 mid-operation: the FSM finishes the current row and drains existing debt; no new ticks are generated.
- Reset mid-ISSUE: ref_req drops asynchronously and the pending row is abandoned (no retry).

Decomposition:
- Shared package rowref_pkg:
  - FSM state enum (IDLE, QUERY, WAIT, DECIDE, ISSUE).
  - ROW_WIDTH default.
  - Debt width function clog2(MAX_DEBT+1).
- One sub-module: refresh_interval_timer. Contains the TREFI counter with enable; outputs tick.
- FSM, debt counter, pointer and statistics stay in the top level.

Test Plan:
- Bench setup: TREFI=8, MAX_DEBT=4, DREF_LAT=1, ROW_WIDTH=4 unless noted.
- Reset then enable=1, dref tied 0:
  - First to_refresh in cycle 9 after reset release, with Ra=0.
  - Ra increments by 1 every 8 cycles.
  - skip_cnt=16 and one round_done pulse after 16 ticks; ref_req never asserts.
- dref=1 for Ra=3 only, ref_ack returned 2 cycles after ref_req:
  - ref_req asserts with ref_row=3 and stays high exactly until ack.
  - Next query is Ra=4; skip_cnt increases by 15 per round.
- Hold ref_ack=0 with dref=1:
  - debt reaches 4 and urgent=1.
  - The next tick sets debt_ovf; debt stays 4.
  - Releasing ack drains debt back to 0 with consecutive queries.
- Tick coincident with ack completion: debt unchanged in that cycle. Check with debt=2.
- Assert rst during ISSUE: ref_req drops in the same cycle.
  - All counters are 0 and Ra=0 after release.
  - debt_ovf is cleared.
- DREF_LAT=0 build: no WAIT state; a skipped row takes QUERY+DECIDE.
  - to_refresh-to-next-IDLE is 2 cycles.

Source files
------------

// File: rtl/rowref_pkg.sv
// ----------------------------------------------------------------------------
// rowref_pkg: shared types and helpers for the refresh row sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rowref_pkg;

  localparam int ROW_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QUERY  = 3'd1,
    WAIT   = 3'd2,
    DECIDE = 3'd3,
    ISSUE  = 3'd4
  } state_t;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/refresh_interval_timer.sv
// ----------------------------------------------------------------------------
// refresh_interval_timer: free-running TREFI counter gated by enable. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module refresh_interval_timer
  import rowref_pkg::*;
#(
  parameter int TREFI = 7800
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = clog2(TREFI);
  localparam logic [CW-1:0] LAST = CW'(TREFI - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Disabling freezes the count so a resumed interval keeps its progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/refresh_row_sequencer.sv
// ----------------------------------------------------------------------------
// refresh_row_sequencer: paces refresh, queries each row, issues REF only when
// the tracker reports the row dirty. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module refresh_row_sequencer
  import rowref_pkg::*;
#(
  parameter int ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int TREFI     = 7800,
  parameter int MAX_DEBT  = 8,
  parameter int DREF_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 to_refresh,
  output logic [ROW_WIDTH-1:0] Ra,
  input  logic                 dref,
  output logic                 ref_req,
  output logic [ROW_WIDTH-1:0] ref_row,
  input  logic                 ref_ack,
  output logic                 urgent,
  output logic                 round_done,
  output logic [15:0]          skip_cnt,
  output logic                 debt_ovf
);

  localparam int DW = clog2(MAX_DEBT + 1);
  localparam logic [DW-1:0] DEBT_MAX = DW'(MAX_DEBT);

  state_t               state;
  state_t               state_nx;
  logic [ROW_WIDTH-1:0] ptr;
  logic [DW-1:0]        debt;
  logic                 dref_r;
  logic                 tick;
  logic                 sample;
  logic                 skip_done;
  logic                 ack_done;
  logic                 complete;

  refresh_interval_timer #(
    .TREFI (TREFI)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // With zero latency the verdict arrives alongside the query strobe.
  assign sample    = (DREF_LAT == 0) ? (state == QUERY) : (state == WAIT);
  assign skip_done = (state == DECIDE) && !dref_r;
  assign ack_done  = (state == ISSUE) && ref_ack;
  assign complete  = skip_done || ack_done;

  assign to_refresh = (state == QUERY);
  assign Ra         = ptr;
  assign ref_req    = (state == ISSUE);
  assign urgent     = (debt == DEBT_MAX);
  assign round_done = complete && (&ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (debt != '0) state_nx = QUERY;
      QUERY:   state_nx = (DREF_LAT == 0) ? DECIDE : WAIT;
      WAIT:    state_nx = DECIDE;
      DECIDE:  state_nx = dref_r ? ISSUE : IDLE;
      ISSUE:   if (ref_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dref_r   <= 1'b0;
      ref_row  <= '0;
      ptr      <= '0;
      skip_cnt <= '0;
      debt     <= '0;
      debt_ovf <= 1'b0;
    end else begin
      if (sample) begin
        dref_r <= dref;
      end
      if ((state == DECIDE) && dref_r) begin
        ref_row <= ptr;
      end
      if (complete) begin
        ptr <= ptr + ROW_WIDTH'(1);
      end
      if (skip_done && (skip_cnt != 16'hFFFF)) begin
        skip_cnt <= skip_cnt + 16'd1;
      end
      // A tick that finds the debt full is lost and flagged.
      if (tick && !complete) begin
        if (urgent) begin
          debt_ovf <= 1'b1;
        end else begin
          debt <= debt + DW'(1);
        end
      end else if (!tick && complete) begin
        debt <= debt - DW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_refresh_row_sequencer.sv
// ----------------------------------------------------------------------------
// tb_refresh_row_sequencer: directed stimulus with a timeline reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_refresh_row_sequencer;

  localparam int RW    = 4;
  localparam int TREFI = 8;
  localparam int MAXD  = 4;
  localparam int LAT   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          dref = 1'b0;
  logic          ref_ack = 1'b0;
  logic          to_refresh, ref_req, urgent, round_done, debt_ovf;
  logic [RW-1:0] ra, ref_row;
  logic [15:0]   skip_cnt;

  logic          dref_1 = 1'b0;
  logic          ack_1 = 1'b0;
  logic          to_refresh_1, ref_req_1, urgent_1, round_done_1, debt_ovf_1;
  logic [RW-1:0] ra_1, ref_row_1;
  logic [15:0]   skip_cnt_1;

  refresh_row_sequencer #(.ROW_WIDTH(RW), .TREFI(TREFI), .MAX_DEBT(MAXD), .DREF_LAT(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .to_refresh(to_refresh), .Ra(ra), .dref(dref),
    .ref_req(ref_req), .ref_row(ref_row), .ref_ack(ref_ack), .urgent(urgent),
    .round_done(round_done), .skip_cnt(skip_cnt), .debt_ovf(debt_ovf));

  refresh_row_sequencer #(.ROW_WIDTH(RW), .TREFI(TREFI), .MAX_DEBT(MAXD), .DREF_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .to_refresh(to_refresh_1), .Ra(ra_1), .dref(dref_1),
    .ref_req(ref_req_1), .ref_row(ref_row_1), .ref_ack(ack_1), .urgent(urgent_1),
    .round_done(round_done_1), .skip_cnt(skip_cnt_1), .debt_ovf(debt_ovf_1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: debt, interval and per-row timeline measured in cycles.
  int m_cnt, m_debt, m_ptr, m_skip, m_age, m_rrow;
  bit m_ovf, m_busy, m_iss, m_need;

  always @(negedge clk) begin : model
    bit e_tr, e_req, decide, comp, tick;
    if (rst) begin
      m_cnt = 0; m_debt = 0; m_ptr = 0; m_skip = 0; m_age = 0; m_rrow = 0;
      m_ovf = 0; m_busy = 0; m_iss = 0; m_need = 0;
    end else begin
      e_tr   = m_busy && !m_iss && (m_age == 0);
      e_req  = m_busy && m_iss;
      decide = m_busy && !m_iss && (m_age == 1 + LAT);
      comp   = (decide && !m_need) || (m_iss && ref_ack);
      tick   = enable && (m_cnt == TREFI - 1);
      chk("to_refresh", to_refresh, e_tr);
      if (e_tr) chk("Ra", ra, m_ptr);
      chk("ref_req", ref_req, e_req);
      if (e_req) chk("ref_row", ref_row, m_rrow);
      chk("urgent", urgent, m_debt == MAXD);
      chk("round_done", round_done, comp && (m_ptr == (1 << RW) - 1));
      chk("skip_cnt", skip_cnt, m_skip);
      chk("debt_ovf", debt_ovf, m_ovf);
      if (m_busy) begin
        if (m_iss) begin
          if (ref_ack) begin m_busy = 0; m_iss = 0; end
        end else begin
          if (m_age == LAT) m_need = dref;
          if (m_age == 1 + LAT) begin
            if (m_need) begin m_iss = 1; m_rrow = m_ptr; end
            else m_busy = 0;
          end
          m_age++;
        end
      end else if (m_debt > 0) begin
        m_busy = 1; m_age = 0; m_iss = 0;
      end
      if (comp) begin
        m_ptr = (m_ptr + 1) % (1 << RW);
        if (decide && m_skip < 65535) m_skip++;
      end
      if (tick && !comp) begin
        if (m_debt == MAXD) m_ovf = 1; else m_debt++;
      end else if (!tick && comp) begin
        m_debt--;
      end
      if (enable) m_cnt = (m_cnt == TREFI - 1) ? 0 : m_cnt + 1;
    end
  end

  // Tracker/arbiter responder, applied just after each rising edge.
  int       cyc = 0;
  int       dmode = 0;
  int       amode = 0;
  int       rq_age = 0;
  bit       en_req = 0;
  bit       seen_req_1 = 0;
  logic [RW-1:0] q_ra = '0;

  task automatic respond();
    enable = en_req;
    if (to_refresh) q_ra = ra;
    case (dmode)
      1:       dref = (q_ra == 4'd3);
      2:       dref = 1'b1;
      default: dref = 1'b0;
    endcase
    rq_age = ref_req ? rq_age + 1 : 0;
    case (amode)
      1:       ref_ack = (rq_age == 3);
      2:       ref_ack = 1'b1;
      3:       ref_ack = ref_req;
      4:       ref_ack = ref_req && enable && (m_cnt == TREFI - 1) && (m_debt == 2);
      default: ref_ack = 1'b0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    respond();
    @(negedge clk);
    if (ref_req_1) seen_req_1 = 1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    respond();
    @(negedge clk);
  endtask

  initial begin : stim
    int s0, nq, lastc, rd0, rd1, req_len, last_q;
    bit done;

    // Skip-only sweep; ack held high to show it is ignored outside ISSUE.
    en_req = 1; dmode = 0; amode = 2;
    repeat (3) step();
    release_rst();
    rd0 = 0; rd1 = 0; req_len = 0;
    while (cyc < 136) begin
      step();
      if (cyc == 8) chk("a_no_early_query", to_refresh, 0);
      if (cyc >= 9 && cyc <= 129 && ((cyc - 9) % 8 == 0)) begin
        chk("a_query", to_refresh, 1);
        chk("a_ra", ra, (cyc - 9) / 8);
      end
      if (cyc == 9)  begin chk("l0_query", to_refresh_1, 1); chk("l0_ra", ra_1, 0); end
      if (cyc == 10) chk("l0_skip_c10", skip_cnt_1, 0);
      if (cyc == 11) begin chk("l0_skip_c11", skip_cnt_1, 1); chk("l1_skip_c11", skip_cnt, 0); end
      if (cyc == 12) chk("l1_skip_c12", skip_cnt, 1);
      if (round_done) rd0++;
      if (round_done_1) rd1++;
      if (ref_req) req_len++;
    end
    chk("a_skip_total", skip_cnt, 16);
    chk("a_round_pulses", rd0, 1);
    chk("a_ref_req_cycles", req_len, 0);
    chk("l0_skip_total", skip_cnt_1, 16);
    chk("l0_round_pulses", rd1, 1);

    // Only row 3 is dirty; arbiter acks on the third request cycle.
    dmode = 1; amode = 1;
    s0 = skip_cnt; req_len = 0; last_q = -1; done = 0; nq = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (to_refresh) begin
        if (last_q == 3) begin chk("b_after_row3", ra, 4); nq++; end
        last_q = ra;
      end
      if (ref_req) begin req_len++; chk("b_ref_row", ref_row, 3); end
      if (round_done) done = 1;
    end
    chk("b_round_done_seen", done, 1);
    step(); step();
    chk("b_skip_delta", skip_cnt - s0, 15);
    chk("b_req_len", req_len, 3);
    chk("b_row4_checked", nq, 1);

    // Ack withheld: debt saturates, then one more tick is lost.
    dmode = 2; amode = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (urgent) done = 1;
    end
    chk("c_urgent_reached", done, 1);
    chk("c_ovf_before", debt_ovf, 0);
    repeat (7) step();
    chk("c_ovf_pre_tick", debt_ovf, 0);
    step();
    chk("c_ovf_set", debt_ovf, 1);
    chk("c_urgent_held", urgent, 1);
    en_req = 0; dmode = 0; amode = 3;
    nq = 0; lastc = -1;
    repeat (40) begin
      step();
      if (to_refresh) begin
        nq++;
        if (lastc >= 0) chk("c_drain_spacing", cyc - lastc, 4);
        lastc = cyc;
      end
    end
    chk("c_drain_queries", nq, 3);
    chk("c_urgent_cleared", urgent, 0);
    chk("c_ovf_sticky", debt_ovf, 1);

    // Completion coincides with a tick at debt 2: two rows remain afterwards.
    en_req = 1; dmode = 2; amode = 4; done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      step();
      if (ref_ack && ref_req) done = 1;
    end
    chk("d_coincident_ack", done, 1);
    en_req = 0; dmode = 0; amode = 0; nq = 0;
    repeat (30) begin
      step();
      if (to_refresh) nq++;
    end
    chk("d_rows_left", nq, 2);

    // Reset in the middle of a REF request.
    en_req = 1; dmode = 2; amode = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (ref_req) done = 1;
    end
    chk("e_issue_reached", done, 1);
    chk("e_ovf_before_rst", debt_ovf, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("e_ref_req_async", ref_req, 0);
    chk("e_ovf_cleared", debt_ovf, 0);
    chk("e_skip_zero", skip_cnt, 0);
    chk("e_ra_zero", ra, 0);
    chk("e_ref_row_zero", ref_row, 0);
    chk("e_urgent_zero", urgent, 0);
    chk("e_to_refresh_zero", to_refresh, 0);
    @(negedge clk);
    dmode = 0;
    step(); step();
    release_rst();
    while (cyc < 9) begin
      step();
      if (cyc == 8) chk("e_no_early_query", to_refresh, 0);
    end
    chk("e_first_query", to_refresh, 1);
    chk("e_first_ra", ra, 0);

    chk("l0_never_req", seen_req_1, 0);
    chk("l0_no_ovf", debt_ovf_1, 0);
    chk("l0_not_urgent", urgent_1, 0);
    chk("l0_ref_row", ref_row_1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
